// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: fetches over a req/ack handshake,
// holds the instruction for the control unit, and computes the next PC.
module pc_fetch_unit #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               jump,
  input  logic               branch,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         op,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic               fetch_err
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ERROR
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_ir;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_err;
  logic [WAIT_W-1:0]    r_wait;

  logic                 w_load_ir;
  logic                 w_retire;
  logic                 w_wait_inc;
  logic [ADDR_W-1:0]    w_pc_next;
  logic [ADDR_W-1:0]    w_boff;
  logic [ADDR_W-1:0]    w_jtgt;

  assign w_boff = ADDR_W'($signed(r_ir[5:0]));
  assign w_jtgt = ADDR_W'(r_ir[11:0]);

  always_comb begin
    w_state_next = r_state;
    w_load_ir    = 1'b0;
    w_retire     = 1'b0;
    w_wait_inc   = 1'b0;
    imem_req     = 1'b0;
    ir_valid     = 1'b0;
    unique case (r_state)
      S_IDLE:  w_state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_load_ir    = 1'b1;
          w_state_next = S_EXEC;
        end else if (r_wait == WAIT_LAST) begin
          w_state_next = S_ERROR;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_EXEC: begin
        ir_valid = 1'b1;
        if (!stall) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_ERROR: w_state_next = S_ERROR;
      default: w_state_next = S_IDLE;
    endcase
  end

  // jump outranks branch; everything wraps modulo 2^ADDR_W
  always_comb begin
    w_pc_next = r_pc + ADDR_W'(1);
    if (jump) begin
      w_pc_next = w_jtgt;
    end else if (branch) begin
      w_pc_next = r_pc + ADDR_W'(1) + w_boff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_inc ? r_wait + WAIT_W'(1) : '0;
      if (w_load_ir) begin
        r_ir <= imem_rdata;
      end
      if (w_retire) begin
        r_pc  <= w_pc_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_state_next == S_ERROR) begin
        r_err <= 1'b1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign op          = r_ir[INSTR_W-1 -: 4];
  assign retired_cnt = r_cnt;
  assign fetch_err   = r_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, jump/branch, wrap/stall,
// fetch timeout and asynchronous reset during a fetch.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic [3:0]  op;
  logic        ir_valid;
  logic [11:0] pc;
  logic [15:0] retired_cnt;
  logic        fetch_err;

  logic        auto_en = 1'b0;
  logic        man_ack = 1'b0;
  logic [15:0] man_rdata = '0;
  logic [15:0] rom [0:4095];

  int checks = 0;
  int errors = 0;

  assign imem_ack   = auto_en ? imem_req : man_ack;
  assign imem_rdata = auto_en ? rom[imem_addr] : man_rdata;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .ADDR_W (12),
    .INSTR_W(16),
    .TIMEOUT(4),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .jump       (jump),
    .branch     (branch),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .op         (op),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .retired_cnt(retired_cnt),
    .fetch_err  (fetch_err)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({imem_req, ir_valid, fetch_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {imem_req, ir_valid, fetch_err});
    end
    checks++; if (pc !== 12'h000) begin
      errors++; $display("FAIL reset_pc got %h exp 000", pc);
    end
    checks++; if (ir !== 16'h0000) begin
      errors++; $display("FAIL reset_ir got %h exp 0000", ir);
    end
    checks++; if (retired_cnt !== 16'h0000) begin
      errors++; $display("FAIL reset_cnt got %h exp 0000", retired_cnt);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] prog [3];
    prog[0] = 16'h2123; prog[1] = 16'h0456; prog[2] = 16'h3789;
    for (int k = 0; k < 3; k++) rom[k] = prog[k];
    auto_en = 1'b1;
    rst_n   = 1'b1;
    checks++; if (imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_req got %b exp 0", imem_req);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({imem_req, ir_valid, imem_addr} !== {2'b10, 12'(k)}) begin
        errors++; $display("FAIL seq_fetch%0d got req=%b v=%b addr=%h exp 1 0 %h",
                           k, imem_req, ir_valid, imem_addr, 12'(k));
      end
      @(negedge clk);
      checks++; if ({ir_valid, imem_req, ir, pc} !== {2'b10, prog[k], 12'(k)}) begin
        errors++; $display("FAIL seq_exec%0d got v=%b req=%b ir=%h pc=%h exp 1 0 %h %h",
                           k, ir_valid, imem_req, ir, pc, prog[k], 12'(k));
      end
      checks++; if (op !== prog[k][15:12]) begin
        errors++; $display("FAIL seq_op%0d got %h exp %h", k, op, prog[k][15:12]);
      end
    end
    @(negedge clk);
    checks++; if ({imem_req, imem_addr, retired_cnt} !== {1'b1, 12'h003, 16'd3}) begin
      errors++; $display("FAIL seq_end got req=%b addr=%h cnt=%0d exp 1 003 3",
                         imem_req, imem_addr, retired_cnt);
    end
  endtask

  task automatic test_jump();
    rom[12'h003] = 16'h7ABC;
    @(negedge clk);
    checks++; if ({ir_valid, ir} !== {1'b1, 16'h7ABC}) begin
      errors++; $display("FAIL jump_ir got v=%b ir=%h exp 1 7abc", ir_valid, ir);
    end
    jump = 1'b1;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 12'hABC}) begin
      errors++; $display("FAIL jump_addr got req=%b addr=%h exp 1 abc", imem_req, imem_addr);
    end
    jump = 1'b0;
    rom[12'hABC] = 16'h7ABC;
    @(negedge clk);
    jump = 1'b1; branch = 1'b1;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 12'hABC}) begin
      errors++; $display("FAIL jump_prio got req=%b addr=%h exp 1 abc", imem_req, imem_addr);
    end
    jump = 1'b0; branch = 1'b0;
  endtask

  task automatic test_branch();
    rom[12'hABC] = 16'h7010;
    @(negedge clk);
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    rom[12'h010] = 16'hD03E;
    checks++; if (imem_addr !== 12'h010) begin
      errors++; $display("FAIL br_setup got %h exp 010", imem_addr);
    end
    @(negedge clk);
    checks++; if ({ir, pc} !== {16'hD03E, 12'h010}) begin
      errors++; $display("FAIL br_back_ir got ir=%h pc=%h exp d03e 010", ir, pc);
    end
    branch = 1'b1;
    @(negedge clk);
    branch = 1'b0;
    checks++; if (imem_addr !== 12'h00F) begin
      errors++; $display("FAIL br_back got %h exp 00f", imem_addr);
    end
    rom[12'h00F] = 16'hF000;
    rom[12'h010] = 16'hE005;
    @(negedge clk);
    branch = 1'b1;
    @(negedge clk);
    branch = 1'b0;
    checks++; if (imem_addr !== 12'h010) begin
      errors++; $display("FAIL br_zero_off got %h exp 010", imem_addr);
    end
    @(negedge clk);
    checks++; if ({ir, pc} !== {16'hE005, 12'h010}) begin
      errors++; $display("FAIL br_fwd_ir got ir=%h pc=%h exp e005 010", ir, pc);
    end
    branch = 1'b1;
    @(negedge clk);
    branch = 1'b0;
    checks++; if (imem_addr !== 12'h016) begin
      errors++; $display("FAIL br_fwd got %h exp 016", imem_addr);
    end
  endtask

  task automatic test_wrap_stall();
    rom[12'h016] = 16'h7FFF;
    @(negedge clk);
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    rom[12'hFFF] = 16'h1234;
    checks++; if (imem_addr !== 12'hFFF) begin
      errors++; $display("FAIL wrap_setup got %h exp fff", imem_addr);
    end
    @(negedge clk);
    checks++; if ({ir_valid, ir, retired_cnt} !== {1'b1, 16'h1234, 16'd10}) begin
      errors++; $display("FAIL stall_entry got v=%b ir=%h cnt=%0d exp 1 1234 10",
                         ir_valid, ir, retired_cnt);
    end
    stall = 1'b1; jump = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({ir_valid, imem_req, ir, pc, retired_cnt} !==
                    {2'b10, 16'h1234, 12'hFFF, 16'd10}) begin
        errors++; $display("FAIL stall_hold%0d got v=%b req=%b ir=%h pc=%h cnt=%0d exp 1 0 1234 fff 10",
                           c, ir_valid, imem_req, ir, pc, retired_cnt);
      end
    end
    stall = 1'b0; jump = 1'b0;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr, retired_cnt} !== {1'b1, 12'h000, 16'd11}) begin
      errors++; $display("FAIL wrap got req=%b addr=%h cnt=%0d exp 1 000 11",
                         imem_req, imem_addr, retired_cnt);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    rst_n = 1'b0; auto_en = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req) req_cycles++;
    end
    checks++; if (req_cycles !== 4) begin
      errors++; $display("FAIL timeout_req_cycles got %0d exp 4", req_cycles);
    end
    checks++; if ({fetch_err, imem_req, ir_valid} !== 3'b100) begin
      errors++; $display("FAIL timeout_err got err=%b req=%b v=%b exp 1 0 0",
                         fetch_err, imem_req, ir_valid);
    end
    man_ack = 1'b1; man_rdata = 16'h1111;
    repeat (2) @(negedge clk);
    man_ack = 1'b0;
    checks++; if ({fetch_err, imem_req, ir_valid, ir} !== {3'b100, 16'h0000}) begin
      errors++; $display("FAIL error_sticky got err=%b req=%b v=%b ir=%h exp 1 0 0 0000",
                         fetch_err, imem_req, ir_valid, ir);
    end

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL err_cleared got %b exp 0", fetch_err);
    end
    repeat (4) @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin
      errors++; $display("FAIL late_ack_req got %b exp 1", imem_req);
    end
    man_ack = 1'b1; man_rdata = 16'h5A5A;
    @(negedge clk);
    man_ack = 1'b0;
    checks++; if ({ir_valid, fetch_err, ir} !== {2'b10, 16'h5A5A}) begin
      errors++; $display("FAIL late_ack got v=%b err=%b ir=%h exp 1 0 5a5a",
                         ir_valid, fetch_err, ir);
    end
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 12'h001}) begin
      errors++; $display("FAIL late_ack_next got req=%b addr=%h exp 1 001", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    man_ack = 1'b1; man_rdata = 16'h9999;
    rst_n = 1'b0;
    @(negedge clk);
    man_ack = 1'b0;
    checks++; if ({ir, pc} !== {16'h0000, 12'h000}) begin
      errors++; $display("FAIL rstmid_regs got ir=%h pc=%h exp 0000 000", ir, pc);
    end
    checks++; if ({imem_req, ir_valid, fetch_err, retired_cnt} !== {3'b000, 16'd0}) begin
      errors++; $display("FAIL rstmid_out got req=%b v=%b err=%b cnt=%0d exp 0 0 0 0",
                         imem_req, ir_valid, fetch_err, retired_cnt);
    end
    auto_en = 1'b1;
    rst_n   = 1'b1;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 12'h000}) begin
      errors++; $display("FAIL rstmid_restart got req=%b addr=%h exp 1 000", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++; if ({ir_valid, ir} !== {1'b1, 16'h2123}) begin
      errors++; $display("FAIL rstmid_refetch got v=%b ir=%h exp 1 2123", ir_valid, ir);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = '0;
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_wrap_stall();
    test_timeout();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
